weight_fetch_ctrl: RTL and testbench

WEIGHT_FETCH_CTRL -- requirements
Module: weight_fetch_ctrl

---
 rtl/conv_pkg.sv | 23 ++
 rtl/wf_sync_fifo.sv | 57 +++++
 rtl/weight_fetch_ctrl.sv | 162 ++++++++++++++++
 tb/tb_weight_fetch_ctrl.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// ============================================================================
// Module   : conv_pkg
// Brief    : Shared types and constants for the convolution weight path.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package conv_pkg;

  localparam int LANE_WIDTH     = 16;
  localparam int LANES          = 9;
  localparam int DEF_ADDR_WIDTH = 8;
  localparam int DEF_DATA_WIDTH = LANE_WIDTH * LANES;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2
  } wf_state_e;

endpackage

`default_nettype wire

// File: rtl/wf_sync_fifo.sv
// ============================================================================
// Module   : wf_sync_fifo
// Brief    : Single-clock FIFO with fall-through read port (power-of-two depth).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module wf_sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 145
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_wr_en,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_en,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_empty
);

  localparam int c_ptr_w = $clog2(DEPTH);
  localparam int c_cnt_w = c_ptr_w + 1;

  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_cnt_w-1:0] r_count;
  logic               w_rd;

  assign o_empty   = (r_count == '0);
  assign w_rd      = i_rd_en && !o_empty;
  assign o_rd_data = r_mem[r_rd_ptr];

  // The writer never exceeds DEPTH outstanding entries, so no full guard here.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_wr_en) begin
        r_mem[r_wr_ptr] <= i_wr_data;
        r_wr_ptr        <= r_wr_ptr + c_ptr_w'(1);
      end
      if (w_rd) begin
        r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
      end
      r_count <= r_count + c_cnt_w'(i_wr_en) - c_cnt_w'(w_rd);
    end
  end

endmodule

`default_nettype wire

// File: rtl/weight_fetch_ctrl.sv
// ============================================================================
// Module   : weight_fetch_ctrl
// Brief    : Streams a run of 3x3 weight words from ROM into the conv engine.
//            Optional run_words handshake counter: define WEIGHT_FETCH_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module weight_fetch_ctrl
  import conv_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   word_cnt,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_rd_data,
  output logic                  w_valid,
  input  logic                  w_ready,
  output logic [DATA_WIDTH-1:0] w_data,
  output logic                  w_last
`ifdef WEIGHT_FETCH_CNT_EN
  ,
  output logic [ADDR_WIDTH:0]   run_words
`endif
);

  localparam int               c_res_w    = $clog2(FIFO_DEPTH) + 1;
  localparam int               c_cnt_w    = ADDR_WIDTH + 1;
  localparam logic [c_res_w-1:0] c_res_full = c_res_w'(FIFO_DEPTH);

  wf_state_e           r_state;
  logic [ADDR_WIDTH-1:0] r_base;
  logic [c_cnt_w-1:0]  r_word_cnt;
  logic [c_cnt_w-1:0]  r_issue_idx;
  logic [c_res_w-1:0]  r_reserved;
  logic                r_zero_run;
  logic                r_rd_pend;
  logic                r_last_pend;
  logic                r_fifo_wr;
  logic                r_fifo_last;

  logic                w_accept;
  logic                w_fetch_issue;
  logic                w_issue;
  logic                w_hs;
  logic                w_fifo_empty;
  logic [DATA_WIDTH:0] w_fifo_dout;

  assign w_accept      = (r_state == ST_IDLE) && start;
  assign w_fetch_issue = (r_state == ST_FETCH) && (r_issue_idx != r_word_cnt) &&
                         (r_reserved < c_res_full);
  // The first read is launched straight from the accepting edge.
  assign w_issue       = w_fetch_issue || (w_accept && (word_cnt != '0));
  assign w_hs          = w_valid && w_ready;

  assign w_valid = ~w_fifo_empty;
  assign w_data  = w_fifo_dout[DATA_WIDTH-1:0];
  assign w_last  = w_fifo_dout[DATA_WIDTH] & w_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_base      <= '0;
      r_word_cnt  <= '0;
      r_issue_idx <= '0;
      r_reserved  <= '0;
      r_zero_run  <= 1'b0;
      r_rd_pend   <= 1'b0;
      r_last_pend <= 1'b0;
      r_fifo_wr   <= 1'b0;
      r_fifo_last <= 1'b0;
      rom_addr    <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      // rom_addr -> ROM data one cycle later -> FIFO write on the following edge
      r_rd_pend   <= w_issue;
      r_last_pend <= 1'b0;
      r_fifo_wr   <= r_rd_pend;
      r_fifo_last <= r_last_pend;
      r_reserved  <= r_reserved + c_res_w'(w_issue) - c_res_w'(w_hs);
      done        <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          busy <= 1'b0;
          if (start) begin
            busy       <= 1'b1;
            r_base     <= base_addr;
            r_word_cnt <= word_cnt;
            r_zero_run <= (word_cnt == '0);
            if (word_cnt == '0) begin
              r_issue_idx <= '0;
              r_state     <= ST_DRAIN;
            end else begin
              rom_addr    <= base_addr;
              r_issue_idx <= c_cnt_w'(1);
              r_last_pend <= (word_cnt == c_cnt_w'(1));
              r_state     <= ST_FETCH;
            end
          end
        end

        ST_FETCH: begin
          if (r_issue_idx == r_word_cnt) begin
            r_state <= ST_DRAIN;
          end else if (w_fetch_issue) begin
            rom_addr    <= r_base + r_issue_idx[ADDR_WIDTH-1:0];
            r_issue_idx <= r_issue_idx + c_cnt_w'(1);
            r_last_pend <= ((r_issue_idx + c_cnt_w'(1)) == r_word_cnt);
          end
        end

        ST_DRAIN: begin
          if (r_zero_run || (w_hs && w_last)) begin
            r_state    <= ST_IDLE;
            r_zero_run <= 1'b0;
            done       <= 1'b1;
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  wf_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_WIDTH + 1)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .i_wr_en   (r_fifo_wr),
    .i_wr_data ({r_fifo_last, rom_rd_data}),
    .i_rd_en   (w_hs),
    .o_rd_data (w_fifo_dout),
    .o_empty   (w_fifo_empty)
  );

`ifdef WEIGHT_FETCH_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      run_words <= '0;
    end else if (w_accept) begin
      run_words <= '0;
    end else if (w_hs) begin
      run_words <= run_words + c_cnt_w'(1);
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_weight_fetch_ctrl.sv
// ============================================================================
// Module   : tb_weight_fetch_ctrl
// Brief    : Self-checking bench for weight_fetch_ctrl against a run-level model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_weight_fetch_ctrl;

  localparam int AW = 8;
  localparam int DW = 144;
  localparam int FD = 4;
  localparam int NONE = -10;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   word_cnt = '0;
  logic          busy;
  logic          done;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_rd_data = '0;
  logic          w_valid;
  logic          w_ready = 1'b0;
  logic [DW-1:0] w_data;
  logic          w_last;
`ifdef WEIGHT_FETCH_CNT_EN
  logic [AW:0]   run_words;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  weight_fetch_ctrl #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .FIFO_DEPTH (FD)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .base_addr   (base_addr),
    .word_cnt    (word_cnt),
    .busy        (busy),
    .done        (done),
    .rom_addr    (rom_addr),
    .rom_rd_data (rom_rd_data),
    .w_valid     (w_valid),
    .w_ready     (w_ready),
    .w_data      (w_data),
    .w_last      (w_last)
`ifdef WEIGHT_FETCH_CNT_EN
    ,
    .run_words   (run_words)
`endif
  );

  // ROM contents: a distinct hashed pattern per address and lane
  function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
    logic [DW-1:0] v;
    for (int k = 0; k < 9; k++) begin
      v[16*k +: 16] = 16'(a) * 16'h9E37 + 16'(k) * 16'h1234 + 16'h00A5;
    end
    return v;
  endfunction

  function automatic logic [DW-1:0] exp_word(input logic [AW-1:0] b, input int i);
    logic [AW-1:0] a;
    a = b + AW'(i);
    return rom_word(a);
  endfunction

  // synchronous ROM: data for the address seen at one edge appears after it
  always @(posedge clk) rom_rd_data <= rom_word(rom_addr);

  logic [DW-1:0] obs_data[$];
  logic          obs_last[$];
  int            hs_cyc[$];
  int            done_cyc[$];
  logic          obs_valid[$];
  logic          obs_busy[$];
  logic [AW-1:0] obs_addr[$];
`ifdef WEIGHT_FETCH_CNT_EN
  logic [AW:0]   obs_rw[$];
`endif
  int            stab_breaks;
  logic [DW-1:0] snap_data;
  logic [AW-1:0] snap_addr;
  logic          snap_busy, snap_done, snap_valid, snap_last;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one transaction and records what the DUT did, cycle 0 = start cycle.
  task automatic drive_run(input logic [AW-1:0] b, input logic [AW:0] c, input int mode,
                           input int restart_cyc, input int rst_cyc, input int budget);
    int            done_at;
    logic          prev_stall;
    logic [DW-1:0] prev_data;
    logic          prev_last;
    obs_data.delete(); obs_last.delete(); hs_cyc.delete(); done_cyc.delete();
    obs_valid.delete(); obs_busy.delete(); obs_addr.delete();
`ifdef WEIGHT_FETCH_CNT_EN
    obs_rw.delete();
`endif
    stab_breaks = 0;
    done_at = -1;
    prev_stall = 1'b0;
    prev_data = '0;
    prev_last = 1'b0;
    start = 1'b1;
    base_addr = b;
    word_cnt = c;
    for (int cyc = 0; cyc < budget; cyc++) begin
      if (cyc == 1) start = 1'b0;
      if (cyc == restart_cyc) begin
        start = 1'b1;
        base_addr = 8'h80;
        word_cnt = 9'd3;
      end else if (cyc == restart_cyc + 1) begin
        start = 1'b0;
      end
      if (cyc == rst_cyc) begin
        rst = 1'b1;
      end else if (cyc == rst_cyc + 1) begin
        rst = 1'b0;
        snap_data = w_data; snap_addr = rom_addr; snap_busy = busy;
        snap_done = done; snap_valid = w_valid; snap_last = w_last;
      end
      case (mode)
        0:       w_ready = 1'b1;
        1:       w_ready = ((cyc % 2) == 1);
        default: w_ready = ($urandom_range(0, 1) == 1);
      endcase
      if (rst) w_ready = 1'b0;
      obs_addr.push_back(rom_addr);
      obs_valid.push_back(w_valid);
      obs_busy.push_back(busy);
`ifdef WEIGHT_FETCH_CNT_EN
      obs_rw.push_back(run_words);
`endif
      if (done === 1'b1) begin
        done_cyc.push_back(cyc);
        if (done_at < 0) done_at = cyc;
      end
      if (prev_stall && (w_valid !== 1'b1 || w_data !== prev_data || w_last !== prev_last))
        stab_breaks++;
      if (w_valid === 1'b1 && w_ready === 1'b1) begin
        obs_data.push_back(w_data);
        obs_last.push_back(w_last);
        hs_cyc.push_back(cyc);
      end
      prev_stall = w_valid && !w_ready && !rst;
      prev_data = w_data;
      prev_last = w_last;
      if (done_at >= 0 && cyc >= done_at + 2) break;
      if (rst_cyc >= 0 && cyc >= rst_cyc + 6) break;
      tick();
    end
    start = 1'b0;
    w_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    w_ready = 1'b1;
    tick(); tick(); tick();
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b, expected 0", busy); else n_pass++;
    n_checks++; if (done !== 1'b0) $display("FAIL reset_done: got %b, expected 0", done); else n_pass++;
    n_checks++; if (w_valid !== 1'b0) $display("FAIL reset_valid: got %b, expected 0", w_valid); else n_pass++;
    n_checks++; if (w_last !== 1'b0) $display("FAIL reset_last: got %b, expected 0", w_last); else n_pass++;
    n_checks++; if (rom_addr !== 8'h00) $display("FAIL reset_rom_addr: got %h, expected 00", rom_addr); else n_pass++;
    n_checks++; if (w_data !== '0) $display("FAIL reset_w_data: got %h, expected 0", w_data); else n_pass++;
    rst = 1'b0;
    tick(); tick(); tick();
    n_checks++; if (w_valid !== 1'b0 || busy !== 1'b0) $display("FAIL idle_quiet: valid=%b busy=%b, expected 0 0", w_valid, busy); else n_pass++;
    w_ready = 1'b0;
  endtask

  task automatic test_basic_timing();
    int bad;
    int dc;
    drive_run(8'h10, 9'd4, 0, NONE, NONE, 40);
    bad = 0;
    for (int i = 1; i <= 4; i++) if (obs_addr[i] !== 8'h10 + AW'(i - 1)) bad++;
    n_checks++; if (bad != 0) $display("FAIL basic_addr: %0d wrong cycles, expected 0", bad); else n_pass++;
    bad = 0;
    foreach (obs_valid[i]) if (obs_valid[i] !== (i >= 3 && i <= 6)) bad++;
    n_checks++; if (bad != 0) $display("FAIL basic_valid_window: %0d wrong cycles, expected 0", bad); else n_pass++;
    n_checks++;
    if (hs_cyc.size() != 4 || hs_cyc[hs_cyc.size()-1] != 6 || obs_last[obs_last.size()-1] !== 1'b1)
      $display("FAIL basic_last: %0d handshakes, expected 4 with w_last in cycle 6", hs_cyc.size());
    else n_pass++;
    dc = (done_cyc.size() > 0) ? done_cyc[0] : -1;
    n_checks++; if (done_cyc.size() != 1 || dc != 7) $display("FAIL basic_done: pulses=%0d first=%0d, expected 1 at 7", done_cyc.size(), dc); else n_pass++;
    bad = 0;
    foreach (obs_busy[i]) if (obs_busy[i] !== (i >= 1 && i <= 7)) bad++;
    n_checks++; if (bad != 0) $display("FAIL basic_busy: %0d wrong cycles, expected 0", bad); else n_pass++;
    bad = 0;
    foreach (obs_data[i]) if (obs_data[i] !== exp_word(8'h10, i)) bad++;
    n_checks++; if (bad != 0) $display("FAIL basic_data: %0d wrong words, expected 0", bad); else n_pass++;
  endtask

  task automatic test_wrap();
    logic [AW-1:0] iss[$];
    int bad;
    drive_run(8'hFE, 9'd4, 2, NONE, NONE, 200);
    for (int cyc = 1; cyc < obs_addr.size(); cyc++)
      if (cyc == 1 || obs_addr[cyc] !== obs_addr[cyc-1]) iss.push_back(obs_addr[cyc]);
    n_checks++; if (iss.size() != 4) $display("FAIL wrap_issue_count: got %0d, expected 4", iss.size()); else n_pass++;
    bad = 0;
    foreach (iss[i]) if (iss[i] !== 8'hFE + AW'(i)) bad++;
    n_checks++; if (bad != 0) $display("FAIL wrap_addr_order: %0d wrong, expected 0", bad); else n_pass++;
    bad = (obs_data.size() == 4) ? 0 : 1;
    foreach (obs_data[i]) if (obs_data[i] !== exp_word(8'hFE, i)) bad++;
    n_checks++; if (bad != 0) $display("FAIL wrap_data: %0d errors, expected 0", bad); else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [AW-1:0] b;
    int bad, iss, hi, mx;
    b = AW'($urandom_range(0, 255));
    drive_run(b, 9'd10, 1, NONE, NONE, 200);
    n_checks++; if (obs_data.size() != 10) $display("FAIL bp_count: got %0d, expected 10", obs_data.size()); else n_pass++;
    bad = 0;
    foreach (obs_data[i]) if (obs_data[i] !== exp_word(b, i)) bad++;
    n_checks++; if (bad != 0) $display("FAIL bp_data_order: %0d wrong, expected 0", bad); else n_pass++;
    iss = 0; hi = 0; mx = 0;
    for (int cyc = 1; cyc < obs_addr.size(); cyc++) begin
      if (cyc == 1 || obs_addr[cyc] !== obs_addr[cyc-1]) iss++;
      while (hi < hs_cyc.size() && hs_cyc[hi] < cyc) hi++;
      if (iss - hi > mx) mx = iss - hi;
    end
    n_checks++; if (mx != FD) $display("FAIL bp_reserved_peak: got %0d, expected %0d", mx, FD); else n_pass++;
    n_checks++; if (stab_breaks != 0) $display("FAIL bp_stable: %0d breaks, expected 0", stab_breaks); else n_pass++;
  endtask

  task automatic test_zero();
    int nv, na;
    drive_run(8'h33, 9'd0, 0, NONE, NONE, 20);
    nv = 0; na = 0;
    foreach (obs_valid[i]) if (obs_valid[i] === 1'b1) nv++;
    foreach (obs_addr[i]) if (obs_addr[i] !== obs_addr[0]) na++;
    n_checks++; if (nv != 0) $display("FAIL zero_valid: %0d valid cycles, expected 0", nv); else n_pass++;
    n_checks++; if (na != 0) $display("FAIL zero_rom_issue: %0d addr changes, expected 0", na); else n_pass++;
    n_checks++;
    if (done_cyc.size() != 1 || done_cyc[0] != 2)
      $display("FAIL zero_done: pulses=%0d, expected 1 at cycle 2", done_cyc.size());
    else n_pass++;
  endtask

  task automatic test_start_ignored();
    int bad;
    drive_run(8'h20, 9'd6, 2, 3, NONE, 300);
    bad = (obs_data.size() == 6) ? 0 : 1;
    foreach (obs_data[i]) if (obs_data[i] !== exp_word(8'h20, i)) bad++;
    n_checks++; if (bad != 0) $display("FAIL ignore_data: %0d errors, got %0d words, expected 6 clean", bad, obs_data.size()); else n_pass++;
    n_checks++; if (done_cyc.size() != 1) $display("FAIL ignore_done: %0d pulses, expected 1", done_cyc.size()); else n_pass++;
  endtask

  task automatic test_rst_midrun();
    int bad;
    drive_run(8'h40, 9'd8, 0, NONE, 6, 60);
    n_checks++; if (obs_data.size() != 3) $display("FAIL rst_words_before: got %0d, expected 3", obs_data.size()); else n_pass++;
    n_checks++;
    if (snap_busy !== 1'b0 || snap_done !== 1'b0 || snap_valid !== 1'b0 || snap_last !== 1'b0)
      $display("FAIL rst_flags: busy=%b done=%b valid=%b last=%b, expected all 0", snap_busy, snap_done, snap_valid, snap_last);
    else n_pass++;
    n_checks++;
    if (snap_addr !== '0 || snap_data !== '0)
      $display("FAIL rst_buses: rom_addr=%h w_data_nonzero=%b, expected 0", snap_addr, (snap_data != '0));
    else n_pass++;
    n_checks++; if (done_cyc.size() != 0) $display("FAIL rst_no_done: %0d pulses, expected 0", done_cyc.size()); else n_pass++;
    drive_run(8'h50, 9'd2, 0, NONE, NONE, 40);
    bad = (obs_data.size() == 2) ? 0 : 1;
    foreach (obs_data[i]) if (obs_data[i] !== exp_word(8'h50, i)) bad++;
    n_checks++; if (bad != 0) $display("FAIL rst_rerun_data: %0d errors, expected 0", bad); else n_pass++;
    n_checks++;
    if (done_cyc.size() != 1 || done_cyc[0] != 5 || obs_addr[1] !== 8'h50)
      $display("FAIL rst_rerun_timing: pulses=%0d addr1=%h, expected done at 5, addr 50", done_cyc.size(), obs_addr[1]);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [AW-1:0] b;
    logic [AW:0]   c;
    int bad, nl, iss, hi, mx;
    for (int r = 0; r < 6; r++) begin
      b = AW'($urandom_range(0, 255));
      c = (r == 0) ? 9'd256 : 9'($urandom_range(1, 24));
      drive_run(b, c, 2, NONE, NONE, 3000);
      n_checks++; if (obs_data.size() != int'(c)) $display("FAIL rand%0d_count: got %0d, expected %0d", r, obs_data.size(), c); else n_pass++;
      bad = 0; nl = 0;
      foreach (obs_data[i]) begin
        if (obs_data[i] !== exp_word(b, i)) bad++;
        if (obs_last[i] === 1'b1) nl++;
      end
      n_checks++; if (bad != 0) $display("FAIL rand%0d_data: %0d wrong, expected 0", r, bad); else n_pass++;
      n_checks++;
      if (nl != 1 || obs_last.size() == 0 || obs_last[obs_last.size()-1] !== 1'b1)
        $display("FAIL rand%0d_last: %0d flags, expected 1 on final word", r, nl);
      else n_pass++;
      n_checks++;
      if (done_cyc.size() != 1 || hs_cyc.size() == 0 || done_cyc[0] != hs_cyc[hs_cyc.size()-1] + 1)
        $display("FAIL rand%0d_done: %0d pulses, expected 1 right after last handshake", r, done_cyc.size());
      else n_pass++;
      iss = 0; hi = 0; mx = 0;
      for (int cyc = 1; cyc < obs_addr.size(); cyc++) begin
        if (cyc == 1 || obs_addr[cyc] !== obs_addr[cyc-1]) iss++;
        while (hi < hs_cyc.size() && hs_cyc[hi] < cyc) hi++;
        if (iss - hi > mx) mx = iss - hi;
      end
      n_checks++;
      if (mx > FD || stab_breaks != 0)
        $display("FAIL rand%0d_flow: peak reserved %0d (max %0d), %0d stability breaks, expected 0", r, mx, FD, stab_breaks);
      else n_pass++;
    end
  endtask

`ifdef WEIGHT_FETCH_CNT_EN
  task automatic test_run_words();
    int dc;
    drive_run(8'h70, 9'd5, 2, NONE, NONE, 200);
    dc = (done_cyc.size() > 0) ? done_cyc[0] : 0;
    n_checks++; if (obs_rw[1] !== '0) $display("FAIL rw_cleared: got %0d, expected 0", obs_rw[1]); else n_pass++;
    n_checks++; if (obs_rw[dc] !== 9'd5) $display("FAIL rw_at_done: got %0d, expected 5", obs_rw[dc]); else n_pass++;
    n_checks++; if (obs_rw[obs_rw.size()-1] !== 9'd5) $display("FAIL rw_hold: got %0d, expected 5", obs_rw[obs_rw.size()-1]); else n_pass++;
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, got no finish, expected completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic_timing();
    test_wrap();
    test_backpressure();
    test_zero();
    test_start_ignored();
    test_rst_midrun();
    test_random();
`ifdef WEIGHT_FETCH_CNT_EN
    test_run_words();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
